// File: rtl/mseq_pkg.sv
// Shared definitions for the MCP-1631 microprogram sequencer: microword layout,
// op encodings, the address type and default vectors.
package mseq_pkg;

    typedef logic [10:0] addr_t;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JMP  = 3'd1,
        OP_JCC  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_XLAT = 3'd5,
        OP_WAIT = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    localparam int MO_W    = 22;
    localparam int CC_W    = 16;
    localparam int OP_HI   = 21;
    localparam int OP_LO   = 19;
    localparam int TE_BIT  = 18;
    localparam int POL_BIT = 15;
    localparam int SEL_HI  = 14;
    localparam int SEL_LO  = 11;
    localparam int A_HI    = 10;
    localparam int A_LO    = 0;

    localparam addr_t RESET_VEC_D = 11'h000;
    localparam addr_t TRAP_VEC_D  = 11'h7F0;
    localparam int    DEPTH_D     = 4;

    function automatic op_e mo_op(input logic [MO_W-1:0] mo);
        return op_e'(mo[OP_HI:OP_LO]);
    endfunction

endpackage

// File: rtl/mseq_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the oldest
// entry; a pop from an empty stack yields EMPTY_VAL. Both misuse cases are flagged.
module mseq_stack
    import mseq_pkg::*;
#(
    parameter int    DEPTH     = DEPTH_D,
    parameter addr_t EMPTY_VAL = RESET_VEC_D
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  addr_t push_data_i,
    input  logic  pop_i,
    output addr_t top_o,
    output logic  ovf_o,
    output logic  unf_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    addr_t         mem_q [DEPTH];
    logic          empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);
    assign top_o = empty ? EMPTY_VAL : mem_q[ptr_q - PTR_ONE];
    assign ovf_o = push_i & full;
    assign unf_o = pop_i & empty;

    // ptr_q names the next free slot; when full that slot holds the oldest entry.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_ONE;
            if (!full) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (pop_i && !empty) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mseq_lc.sv
// Microprogram sequencer: decodes the word on pin_mo and drives the next
// MicROM location on pin_lc, with a return stack, WAIT stalls and micro-traps.
module mseq_lc
    import mseq_pkg::*;
#(
    parameter addr_t RESET_VEC = RESET_VEC_D,
    parameter addr_t TRAP_VEC  = TRAP_VEC_D,
    parameter int    DEPTH     = DEPTH_D
) (
    input  logic             pin_clk,
    input  logic             pin_nrst,
    input  logic [MO_W-1:0]  pin_mo,
    input  logic [CC_W-1:0]  pin_cc,
    input  logic [10:0]      pin_xa,
    input  logic             pin_rdy,
    input  logic             pin_trap,
    output logic [10:0]      pin_lc,
    output logic             pin_mval,
    output logic             pin_xack,
    output logic             pin_tack,
    output logic             pin_serr
);

    addr_t lc_q;
    logic  val_q;
    logic  serr_q, serr_d;

    op_e        op;
    addr_t      a_fld;
    logic [3:0] sel;
    logic       cond;
    addr_t      lc_inc;
    addr_t      op_addr;
    logic       stall;
    logic       trap_take;
    logic       push, pop;
    addr_t      push_data;
    addr_t      stk_top;
    logic       stk_ovf, stk_unf;
    logic       unused_mo;

    assign op        = mo_op(pin_mo);
    assign a_fld     = pin_mo[A_HI:A_LO];
    assign sel       = pin_mo[SEL_HI:SEL_LO];
    assign cond      = pin_cc[sel] ^ pin_mo[POL_BIT];
    assign lc_inc    = lc_q + 11'd1;
    assign unused_mo = ^pin_mo[17:16];

    // Address the op alone would select, before any trap override.
    always_comb begin
        op_addr = lc_inc;
        case (op)
            OP_NEXT: op_addr = lc_inc;
            OP_JMP:  op_addr = a_fld;
            OP_JCC:  op_addr = cond ? a_fld : lc_inc;
            OP_CALL: op_addr = a_fld;
            OP_RET:  op_addr = stk_top;
            OP_XLAT: op_addr = pin_xa;
            OP_WAIT: op_addr = pin_rdy ? lc_inc : lc_q;
            default: op_addr = lc_inc;
        endcase
    end

    always_comb begin
        stall     = val_q && (op == OP_WAIT) && !pin_rdy;
        trap_take = val_q && !stall && pin_mo[TE_BIT] && pin_trap;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = lc_inc;
        pin_xack  = 1'b0;
        pin_lc    = RESET_VEC;
        if (val_q) begin
            if (trap_take) begin
                push      = 1'b1;
                push_data = op_addr;
                pin_lc    = TRAP_VEC;
            end else begin
                pin_lc   = op_addr;
                push     = !stall && (op == OP_CALL);
                pop      = !stall && (op == OP_RET);
                pin_xack = (op == OP_XLAT);
            end
        end
    end

    assign pin_tack = trap_take;
    assign serr_d   = serr_q | stk_ovf | stk_unf;
    assign pin_mval = val_q;
    assign pin_serr = serr_q;

    mseq_stack #(
        .DEPTH     (DEPTH),
        .EMPTY_VAL (RESET_VEC)
    ) u_stack (
        .clk_i       (pin_clk),
        .rst_ni      (pin_nrst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .top_o       (stk_top),
        .ovf_o       (stk_ovf),
        .unf_o       (stk_unf)
    );

    always_ff @(posedge pin_clk or negedge pin_nrst) begin
        if (!pin_nrst) begin
            lc_q   <= RESET_VEC;
            val_q  <= 1'b0;
            serr_q <= 1'b0;
        end else begin
            lc_q   <= pin_lc;
            val_q  <= 1'b1;
            serr_q <= serr_d;
        end
    end

endmodule

// File: tb/tb_mseq_lc.sv
// Directed bench for mseq_lc: a small MicROM image plus a per-cycle vector table
// of inputs and expected outputs, followed by a few hand-written sequences.
module tb_mseq_lc;
    import mseq_pkg::*;

    typedef struct packed {
        logic        nrst;
        logic [15:0] cc;
        logic        rdy;
        logic        trap;
        logic [10:0] xa;
        logic [10:0] lc;
        logic        mval;
        logic        xack;
        logic        tack;
        logic        serr;
    } vec_t;

    logic        pin_clk = 1'b0;
    logic        pin_nrst = 1'b0;
    logic [21:0] pin_mo = '0;
    logic [15:0] pin_cc = '0;
    logic [10:0] pin_xa = '0;
    logic        pin_rdy = 1'b1;
    logic        pin_trap = 1'b0;
    logic [10:0] pin_lc;
    logic        pin_mval, pin_xack, pin_tack, pin_serr;

    logic [21:0] rom [2048];
    vec_t        vecs [$];
    int          n_vec = 0;
    int          n_err = 0;

    mseq_lc dut (
        .pin_clk  (pin_clk),
        .pin_nrst (pin_nrst),
        .pin_mo   (pin_mo),
        .pin_cc   (pin_cc),
        .pin_xa   (pin_xa),
        .pin_rdy  (pin_rdy),
        .pin_trap (pin_trap),
        .pin_lc   (pin_lc),
        .pin_mval (pin_mval),
        .pin_xack (pin_xack),
        .pin_tack (pin_tack),
        .pin_serr (pin_serr)
    );

    always #5 pin_clk = ~pin_clk;

    // Synchronous ROM: word at pin_lc appears on pin_mo after the edge.
    always @(posedge pin_clk) pin_mo <= rom[pin_lc];

    function automatic logic [21:0] w(input logic [2:0] op, input logic te, input logic pol,
                                      input logic [3:0] sel, input logic [10:0] a);
        return {op, te, 2'b00, pol, sel, a};
    endfunction

    task automatic add(input logic nrst, input logic [15:0] cc, input logic rdy, input logic trap,
                       input logic [10:0] xa, input logic [10:0] lc, input logic mval,
                       input logic xack, input logic tack, input logic serr);
        vecs.push_back({nrst, cc, rdy, trap, xa, lc, mval, xack, tack, serr});
    endtask

    task automatic chk(input string name, input int idx, input logic [10:0] act, input logic [10:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge pin_clk);
        pin_nrst = v.nrst;
        pin_cc   = v.cc;
        pin_rdy  = v.rdy;
        pin_trap = v.trap;
        pin_xa   = v.xa;
        #2;
        chk("lc",   n_vec, pin_lc, v.lc);
        chk("mval", n_vec, 11'(pin_mval), 11'(v.mval));
        chk("xack", n_vec, 11'(pin_xack), 11'(v.xack));
        chk("tack", n_vec, 11'(pin_tack), 11'(v.tack));
        chk("serr", n_vec, 11'(pin_serr), 11'(v.serr));
        n_vec++;
    endtask

    task automatic step(input logic [15:0] cc, input logic trap, input logic [10:0] xa,
                        input logic [10:0] lc, input logic xack, input logic tack, input logic serr);
        vec_t v;
        v = {1'b1, cc, 1'b1, trap, xa, lc, 1'b1, xack, tack, serr};
        apply(v);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        rom[11'h000] = w(OP_NEXT, 0, 0, 0, 0);
        rom[11'h001] = w(OP_JMP,  0, 0, 0, 11'h100);
        rom[11'h100] = w(OP_JCC,  0, 0, 3, 11'h200);
        rom[11'h101] = w(OP_XLAT, 0, 0, 0, 0);
        rom[11'h200] = w(OP_XLAT, 0, 0, 0, 0);
        rom[11'h010] = w(OP_CALL, 0, 0, 0, 11'h300);
        rom[11'h300] = w(OP_CALL, 0, 0, 0, 11'h400);
        rom[11'h400] = w(OP_RET,  0, 0, 0, 0);
        rom[11'h301] = w(OP_RET,  0, 0, 0, 0);
        rom[11'h011] = w(OP_XLAT, 0, 0, 0, 0);
        rom[11'h050] = w(OP_WAIT, 0, 0, 0, 0);
        rom[11'h051] = w(OP_XLAT, 0, 0, 0, 0);
        rom[11'h5A5] = w(OP_XLAT, 0, 0, 0, 0);
        rom[11'h060] = w(OP_JMP,  1, 0, 0, 11'h120);
        rom[11'h7F0] = w(OP_RET,  0, 0, 0, 0);
        rom[11'h120] = w(OP_XLAT, 0, 0, 0, 0);
        rom[11'h070] = w(OP_JMP,  0, 0, 0, 11'h120);
        rom[11'h080] = w(OP_WAIT, 1, 0, 0, 0);
        rom[11'h081] = w(OP_XLAT, 0, 0, 0, 0);
        rom[11'h020] = w(OP_CALL, 0, 0, 0, 11'h600);
        rom[11'h600] = w(OP_CALL, 0, 0, 0, 11'h610);
        rom[11'h610] = w(OP_CALL, 0, 0, 0, 11'h620);
        rom[11'h620] = w(OP_CALL, 0, 0, 0, 11'h630);
        rom[11'h630] = w(OP_CALL, 0, 0, 0, 11'h640);
        rom[11'h640] = w(OP_RET,  0, 0, 0, 0);
        rom[11'h631] = w(OP_RET,  0, 0, 0, 0);
        rom[11'h621] = w(OP_RET,  0, 0, 0, 0);
        rom[11'h611] = w(OP_RET,  0, 0, 0, 0);
        rom[11'h601] = w(OP_RET,  0, 0, 0, 0);
        rom[11'h0A0] = w(OP_JCC,  0, 1, 15, 11'h0B0);
        rom[11'h0A1] = w(OP_RSVD, 0, 0, 0, 0);
        rom[11'h0A2] = w(OP_XLAT, 0, 0, 0, 0);
        rom[11'h0B0] = w(OP_RSVD, 0, 0, 0, 0);
        rom[11'h0B1] = w(OP_XLAT, 1, 0, 0, 0);

        // nrst cc rdy trap xa | lc mval xack tack serr
        add(0, 16'h0, 1, 0, 11'h000, 11'h000, 0, 0, 0, 0);   // held in reset
        add(0, 16'h0, 1, 0, 11'h000, 11'h000, 0, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h000, 0, 0, 0, 0);   // released, word not yet valid
        add(1, 16'h0, 1, 0, 11'h000, 11'h001, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h100, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h101, 1, 0, 0, 0);   // JCC not taken
        add(1, 16'h0, 1, 0, 11'h100, 11'h100, 1, 1, 0, 0);
        add(1, 16'h8, 1, 0, 11'h000, 11'h200, 1, 0, 0, 0);   // JCC taken
        add(1, 16'h0, 1, 0, 11'h7FF, 11'h7FF, 1, 1, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h000, 1, 0, 0, 0);   // 7FF wraps
        add(1, 16'h0, 1, 0, 11'h000, 11'h001, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h100, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h101, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h010, 11'h010, 1, 1, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h300, 1, 0, 0, 0);   // nested call/return
        add(1, 16'h0, 1, 0, 11'h000, 11'h400, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h301, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h011, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h050, 11'h050, 1, 1, 0, 0);
        add(1, 16'h0, 0, 0, 11'h000, 11'h050, 1, 0, 0, 0);   // WAIT stalled x3
        add(1, 16'h0, 0, 0, 11'h000, 11'h050, 1, 0, 0, 0);
        add(1, 16'h0, 0, 0, 11'h000, 11'h050, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h051, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h5A5, 11'h5A5, 1, 1, 0, 0);
        add(1, 16'h0, 1, 0, 11'h060, 11'h060, 1, 1, 0, 0);
        add(1, 16'h0, 1, 1, 11'h000, 11'h7F0, 1, 0, 1, 0);   // trap on JMP 120
        add(1, 16'h0, 1, 0, 11'h000, 11'h120, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h070, 11'h070, 1, 1, 0, 0);
        add(1, 16'h0, 1, 1, 11'h000, 11'h120, 1, 0, 0, 0);   // trap not enabled
        add(1, 16'h0, 1, 0, 11'h080, 11'h080, 1, 1, 0, 0);
        add(1, 16'h0, 0, 1, 11'h000, 11'h080, 1, 0, 0, 0);   // trap deferred by stall
        add(1, 16'h0, 0, 1, 11'h000, 11'h080, 1, 0, 0, 0);
        add(1, 16'h0, 1, 1, 11'h000, 11'h7F0, 1, 0, 1, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h081, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h020, 11'h020, 1, 1, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h600, 1, 0, 0, 0);   // five nested calls
        add(1, 16'h0, 1, 0, 11'h000, 11'h610, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h620, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h630, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h640, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h631, 1, 0, 0, 1);   // overflow now visible
        add(1, 16'h0, 1, 0, 11'h000, 11'h621, 1, 0, 0, 1);
        add(1, 16'h0, 1, 0, 11'h000, 11'h611, 1, 0, 0, 1);
        add(1, 16'h0, 1, 0, 11'h000, 11'h601, 1, 0, 0, 1);
        add(1, 16'h0, 1, 0, 11'h000, 11'h000, 1, 0, 0, 1);   // underflow returns RESET_VEC
        add(1, 16'h0, 1, 0, 11'h000, 11'h001, 1, 0, 0, 1);
        add(1, 16'h0, 1, 0, 11'h000, 11'h100, 1, 0, 0, 1);
        add(1, 16'h0, 1, 0, 11'h000, 11'h101, 1, 0, 0, 1);
        add(1, 16'h0, 1, 0, 11'h010, 11'h010, 1, 1, 0, 1);
        add(1, 16'h0, 1, 0, 11'h000, 11'h300, 1, 0, 0, 1);
        add(1, 16'h0, 1, 0, 11'h000, 11'h400, 1, 0, 0, 1);
        add(0, 16'h0, 1, 0, 11'h000, 11'h000, 0, 0, 0, 0);   // mid-operation reset
        add(1, 16'h0, 1, 0, 11'h000, 11'h000, 0, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h001, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h100, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h101, 1, 0, 0, 0);
        add(1, 16'h0, 1, 0, 11'h400, 11'h400, 1, 1, 0, 0);
        add(1, 16'h0, 1, 0, 11'h000, 11'h000, 1, 0, 0, 0);   // stack was discarded
        add(1, 16'h0, 1, 0, 11'h000, 11'h001, 1, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // JCC with inverted polarity, then the reserved op behaving as NEXT.
        step(16'h0000, 0, 11'h000, 11'h100, 0, 0, 1);
        step(16'h0000, 0, 11'h000, 11'h101, 0, 0, 1);
        step(16'h0000, 0, 11'h0A0, 11'h0A0, 1, 0, 1);
        step(16'h8000, 0, 11'h000, 11'h0A1, 0, 0, 1);
        step(16'h0000, 0, 11'h000, 11'h0A2, 0, 0, 1);
        step(16'h0000, 0, 11'h0A0, 11'h0A0, 1, 0, 1);
        step(16'h0000, 0, 11'h000, 11'h0B0, 0, 0, 1);
        step(16'h0000, 0, 11'h000, 11'h0B1, 0, 0, 1);

        // Trap on an XLAT: xack suppressed, translated address pushed and returned.
        step(16'h0000, 1, 11'h123, 11'h7F0, 0, 1, 1);
        step(16'h0000, 0, 11'h000, 11'h123, 0, 0, 1);
        step(16'h0000, 0, 11'h000, 11'h124, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mseq_lc.md
# mseq_lc

Microprogram sequencer for the MCP-1631 microinstruction store. It produces the 11-bit location counter that addresses the synchronous MicROM and consumes the 22-bit microinstruction the ROM returns one clock later. It decides the next address from the sequencing field of that word:
- increment, jump, conditional jump, call/return through a small return stack, translation, wait-for-ready, or micro-trap.

Every non-stalled cycle retires one microinstruction.

## Interface
- RESET_VEC, 11'h000: address driven during and immediately after reset.
- TRAP_VEC, 11'h7F0: micro-trap entry address.
- DEPTH, 4: return-stack depth, power of two, 2..16.
- pin_clk  in  1  main clock; all state changes on its rising edge.
- pin_nrst  in  1  reset; asynchronous assertion, active-low.
- pin_mo  in  22  microinstruction from the ROM, registered inside the ROM.
- pin_cc  in  16  condition inputs.
- pin_xa  in  11  translation address from the macro-instruction decoder.
- pin_rdy  in  1  bus/ALU ready, used by WAIT.
- pin_trap  in  1  micro-trap request, level-sensitive.
- pin_lc  out  11  next location; combinational from pin_mo and internal state.
- pin_mval  out  1  pin_mo holds a real microinstruction.
- pin_xack  out  1  one-cycle pulse: pin_xa consumed.
- pin_tack  out  1  one-cycle pulse: trap taken.
- pin_serr  out  1  sticky stack error.

## Operation
- Microword fields:
  - mo[21:19]: op.
  - mo[18]: trap enable.
  - mo[15]: condition polarity; 1 = invert.
  - mo[14:11]: condition select.
  - mo[10:0]: address field A.
- Internal registers:
  - lc_q: address of the word currently on pin_mo; loaded with pin_lc on every edge.
  - val_q: loaded with 1 on the first edge after reset.
  - Return stack and pointer.
  - serr_q.
- Ops:
  - 0 NEXT: lc_q+1.
  - 1 JMP: A.
  - 2 JCC: A if pin_cc[sel]^pol, else lc_q+1.
  - 3 CALL: push lc_q+1, go to A.
  - 4 RET: pop.
  - 5 XLAT: pin_xa; pin_xack=1.
  - 6 WAIT: lc_q+1 if pin_rdy, else lc_q (re-fetch the same word).
  - 7: reserved; behaves as NEXT.
- Priority, per cycle with val_q=1:
  - Stall (op WAIT and !pin_rdy). A stalled cycle never takes a trap, pushes, pops or pulses.
  - Then trap (mo[18] & pin_trap): push the address the op would have produced, drive TRAP_VEC, pin_tack=1. The op's own push/pop/xack is suppressed.
  - Then the op.
- When val_q=0, pin_lc=RESET_VEC and pin_mo is ignored. This covers the cycle after reset release.
- Address arithmetic is 11-bit modulo: lc_q=11'h7FF incremented gives 11'h000.
- Stack behaviour:
  - LIFO of DEPTH entries.
  - Push when full overwrites the oldest entry (circular) and sets serr_q.
  - Pop when empty returns RESET_VEC, leaves the pointer at empty, and sets serr_q.
  - serr_q clears only on reset.
- pin_mval = val_q.

## Timing
- Reset values while pin_nrst=0:
  - pin_lc=RESET_VEC.
  - lc_q=RESET_VEC.
  - pin_mval=0.
  - pin_xack=0, pin_tack=0, pin_serr=0.
  - Stack empty.
- Reset is asynchronous on assertion, so mid-operation reset discards the stack immediately.
- Edge E0: first edge with pin_nrst=1. The ROM captures word RESET_VEC and val_q becomes 1.
- From the cycle after E0: pin_mo = rom[RESET_VEC] and the sequencer decodes it. pin_lc is already the next address in that same cycle.
- Throughput is one microword per clock. The ROM adds one cycle of latency, which lc_q tracks.
- pin_lc, pin_xack and pin_tack are combinational in the decode cycle. The stack and serr_q update on the following edge.
- An XLAT, CALL or RET held by a stall counts once, in the releasing cycle.

## Structure
- Package mseq_pkg holds:
  - Op encodings and field bit positions.
  - An 11-bit address typedef.
  - Default vectors.
- Sub-module mseq_stack holds:
  - The DEPTH-entry circular return stack.
  - The push/pop/empty/full logic.
  - Overflow/underflow flags.
- The mseq_lc top keeps the next-address mux, priority logic and lc_q/val_q/serr_q.

## Test plan
- Reset release:
  - Hold pin_nrst=0 → pin_lc=000, pin_mval=0.
  - Release → one cycle with pin_lc=000, pin_mval=0, then pin_mval=1 with word 000 on pin_mo.
- Straight-line and jumps:
  - Word@000=NEXT, 001=JMP A=100, 100=JCC sel=3 pol=0 A=200.
  - With pin_cc[3]=0 → sequence 000,001,100,101.
  - With pin_cc[3]=1 → sequence ending 100,200.
  - Also 7FF NEXT → 000.
- Call/return nesting: CALL 300 at 010, CALL 400 at 300, RET at 400, RET at 301 → addresses 010,300,400,301,011; pin_serr=0.
- Stack overflow and underflow:
  - Five nested CALLs with DEPTH=4, then five RETs → first four return correctly, the fifth returns RESET_VEC.
  - pin_serr rises on the fifth CALL's push and stays 1.
- WAIT and XLAT:
  - WAIT at 050 with pin_rdy low for 3 cycles → pin_lc=050 three times, then 051.
  - XLAT with pin_xa=5A5 → pin_lc=5A5, pin_xack one cycle.
- Trap:
  - pin_trap=1 on a word with mo[18]=1, op JMP A=120 → pin_lc=TRAP_VEC, pin_tack pulse, 120 pushed; a later RET returns 120.
  - Same with mo[18]=0 → no trap.
  - Same during a stalled WAIT → deferred until pin_rdy.
